// File: rtl/multi_digit_display_scanner.sv
// ---------------------------------------------------------------------------
// multi_digit_display_scanner
//
// Multiplexed seven-segment driver for an N-digit common-anode display.
// One digit slot lasts TICK_DIVIDE clocks. Its first cycle is a dead-time
// cycle with every common off, so the previous digit cannot ghost into the
// next one. Data is double-buffered: 'load' captures into shadow registers,
// and the shadow is committed to the displayed (active) set only at a frame
// boundary. This keeps a frame from ever mixing old and new data.
//
// Optional feature macro: SEGDISP_BLINK_EN
//   When defined, a frame counter toggles a blink phase every BLINK_FRAMES
//   frame boundaries. Digits whose captured blink_mask bit is set go fully
//   dark (commons and dp) during the off phase. When the macro is undefined,
//   blink_mask is accepted and ignored.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   digits         packed hex, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp             decimal point per digit, 1 = lit
//   digit_enable   1 = digit may light
//   blank_leading  live (uncaptured) leading-zero blanking enable
//   blink_mask     1 = digit blinks (only with SEGDISP_BLINK_EN)
//   load           one-cycle capture strobe into the shadow registers
//   pending        shadow holds data not yet committed to the display
//   commons        active-low digit selects (registered)
//   segments       active-low {dp,g,f,e,d,c,b,a} (registered)
//   frame_done     one-cycle pulse in the cycle after each frame boundary
// ---------------------------------------------------------------------------
module multi_digit_display_scanner #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int REFRESH_RATE    = 80,
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_DIVIDE     = CLOCK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS),
  parameter int BLINK_FRAMES    = 40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic                    blank_leading,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   commons,
  output logic [7:0]              segments,
  output logic                    frame_done
);

  localparam int TW = $clog2(TICK_DIVIDE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIVIDE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      4'hF:    hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  logic [TW-1:0]           tick_cnt_r;
  logic [IW-1:0]           scan_idx_r;
  logic [4*NUM_DIGITS-1:0] shd_digits_r, act_digits_r;
  logic [NUM_DIGITS-1:0]   shd_dp_r, act_dp_r;
  logic [NUM_DIGITS-1:0]   shd_en_r, act_en_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic                    run_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [3:0]              cur_hex_s;
  logic [6:0]              cur_code_s;
  logic                    cur_dark_s;
  logic                    blink_dark_s;

  assign tick_s = (tick_cnt_r == TICK_LAST);
  // The wrap tick (last slot ending) is the frame boundary.
  assign wrap_s = tick_s && (scan_idx_r == IDX_LAST);

`ifdef SEGDISP_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] shd_blink_r, act_blink_r;
  logic [BW-1:0]         blink_cnt_r;
  logic                  blink_off_r;

  // Blink phase: toggles every BLINK_FRAMES frame boundaries, starts in on phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_off_r <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_off_r <= ~blink_off_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end
  end

  // Blink mask double buffer, committed together with the rest of the frame data.
  always_ff @(posedge clock) begin
    if (reset) begin
      shd_blink_r <= {NUM_DIGITS{1'b0}};
      act_blink_r <= {NUM_DIGITS{1'b0}};
    end else begin
      if (wrap_s && pending) begin
        act_blink_r <= shd_blink_r;
      end
      if (load) begin
        shd_blink_r <= blink_mask;
      end
    end
  end

  assign blink_dark_s = blink_off_r & act_blink_r[scan_idx_r];
`else
  logic unused_blink_s;
  assign unused_blink_s = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_dark_s   = 1'b0;
`endif

  // Slot timing, scan index, frame pulse and shadow/active double buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt_r   <= {TW{1'b0}};
      scan_idx_r   <= {IW{1'b0}};
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      shd_digits_r <= {(4*NUM_DIGITS){1'b0}};
      act_digits_r <= {(4*NUM_DIGITS){1'b0}};
      shd_dp_r     <= {NUM_DIGITS{1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      shd_en_r     <= {NUM_DIGITS{1'b0}};
      act_en_r     <= {NUM_DIGITS{1'b0}};
    end else begin
      tick_cnt_r <= tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
      if (tick_s) begin
        scan_idx_r <= (scan_idx_r == IDX_LAST) ? {IW{1'b0}} : scan_idx_r + IW'(1);
      end
      frame_done <= wrap_s;
      // Commit reads the old shadow, so a load on the boundary cycle is held
      // for the following frame.
      if (wrap_s && pending) begin
        act_digits_r <= shd_digits_r;
        act_dp_r     <= shd_dp_r;
        act_en_r     <= shd_en_r;
      end
      if (load) begin
        shd_digits_r <= digits;
        shd_dp_r     <= dp;
        shd_en_r     <= digit_enable;
        pending      <= 1'b1;
      end else if (wrap_s) begin
        pending      <= 1'b0;
      end
    end
  end

  // Leading-zero blanking: walk down from the top digit while digits are zero.
  always_comb begin
    blank_s = {NUM_DIGITS{1'b0}};
    run_s   = blank_leading;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (run_s && (act_digits_r[4*i +: 4] == 4'h0)) begin
        blank_s[i] = 1'b1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Current digit select and its segment pattern.
  always_comb begin
    sel_s             = {NUM_DIGITS{1'b0}};
    sel_s[scan_idx_r] = 1'b1;
    cur_hex_s         = act_digits_r[{scan_idx_r, 2'b00} +: 4];
    cur_code_s        = blank_s[scan_idx_r] ? 7'h00 : hex_to_seg(cur_hex_s);
    cur_dark_s        = ~act_en_r[scan_idx_r] | blink_dark_s;
  end

  // Pin drivers: dead time in the cycle after a tick, dark digits fully off.
  always_ff @(posedge clock) begin
    if (reset) begin
      commons  <= {NUM_DIGITS{1'b1}};
      segments <= 8'hFF;
    end else if (tick_s || cur_dark_s) begin
      commons  <= {NUM_DIGITS{1'b1}};
      segments <= 8'hFF;
    end else begin
      commons  <= ~sel_s;
      segments <= ~{act_dp_r[scan_idx_r], cur_code_s};
    end
  end

endmodule
